// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (instruction/data), the arbiter and the memory.
// The slave modport is the arbiter's view; the master modport is the ports-plus-memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0, rd0, wr0, last0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              req1, rd1, wr1, last1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;

    logic              gnt0, gnt1, accept0, accept1, rvalid0, rvalid1, busy;
    logic [DATA_W-1:0] rdata;

    logic              mem_rd, mem_wr, mem_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in, mem_data_out;

    modport slave (
        input  req0, rd0, wr0, last0, addr0, wdata0,
        input  req1, rd1, wr1, last1, addr1, wdata1,
        input  mem_data_out, mem_stall,
        output gnt0, gnt1, accept0, accept1, rvalid0, rvalid1, busy, rdata,
        output mem_rd, mem_wr, mem_addr, mem_data_in
    );

    modport master (
        output req0, rd0, wr0, last0, addr0, wdata0,
        output req1, rd1, wr1, last1, addr1, wdata1,
        output mem_data_out, mem_stall,
        input  gnt0, gnt1, accept0, accept1, rvalid0, rvalid1, busy, rdata,
        input  mem_rd, mem_wr, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter with bounded bursts and a read-return tag pipe.
// Define ARB_ROUND_ROBIN_EN for alternating priority; otherwise port 1 (data) always wins.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4,
    parameter int RD_LAT    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [RD_LAT-1:0] r_tagValid, r_tagPort;

    logic              w_gnt0, w_gnt1, w_rd, w_wr, w_req, w_last;
    logic              w_accept, w_done, w_pick1;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    assign w_gnt0 = (r_state == OWN0);
    assign w_gnt1 = (r_state == OWN1);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_lastOwner;

    // Remember who was granted last so a tie goes to the other port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_lastOwner <= 1'b0;
        else if (r_state == IDLE && w_next != IDLE)
            r_lastOwner <= (w_next == OWN1);
    end

    assign w_pick1 = ~r_lastOwner;
`else
    assign w_pick1 = 1'b1;
`endif

    // Owner's signals pass straight through; rd and wr together is a protocol error and issues nothing.
    always_comb begin
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_req   = 1'b0;
        w_last  = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            OWN0: begin
                w_rd    = bus.rd0 & ~bus.wr0;
                w_wr    = bus.wr0 & ~bus.rd0;
                w_req   = bus.req0;
                w_last  = bus.last0;
                w_addr  = bus.addr0;
                w_wdata = bus.wdata0;
            end
            OWN1: begin
                w_rd    = bus.rd1 & ~bus.wr1;
                w_wr    = bus.wr1 & ~bus.rd1;
                w_req   = bus.req1;
                w_last  = bus.last1;
                w_addr  = bus.addr1;
                w_wdata = bus.wdata1;
            end
            default: ;
        endcase
    end

    assign w_accept = (w_gnt0 | w_gnt1) & (w_rd | w_wr) & ~bus.mem_stall;
    assign w_done   = w_accept & (w_last | (r_cnt == CNT_MAX));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req0 & bus.req1)
                    w_next = w_pick1 ? OWN1 : OWN0;
                else if (bus.req1)
                    w_next = OWN1;
                else if (bus.req0)
                    w_next = OWN0;
            end
            OWN0, OWN1: begin
                if (!w_req || w_done)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Every grant passes through IDLE, which also clears the beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE)
                r_cnt <= '0;
            else if (w_accept)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // The tag pipe runs freely so reads of a released owner still return during the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tagValid <= '0;
            r_tagPort  <= '0;
        end else begin
            r_tagValid[0] <= w_accept & w_rd;
            r_tagPort[0]  <= w_gnt1;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagPort[i]  <= r_tagPort[i-1];
            end
        end
    end

    assign bus.gnt0        = w_gnt0;
    assign bus.gnt1        = w_gnt1;
    assign bus.busy        = w_gnt0 | w_gnt1;
    assign bus.accept0     = w_accept & w_gnt0;
    assign bus.accept1     = w_accept & w_gnt1;
    assign bus.rvalid0     = r_tagValid[RD_LAT-1] & ~r_tagPort[RD_LAT-1];
    assign bus.rvalid1     = r_tagValid[RD_LAT-1] &  r_tagPort[RD_LAT-1];
    assign bus.rdata       = bus.mem_data_out;
    assign bus.mem_rd      = w_rd;
    assign bus.mem_wr      = w_wr;
    assign bus.mem_addr    = w_addr;
    assign bus.mem_data_in = w_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; a two-deep memory model returns addr^5A5A RD_LAT cycles after each address.
// Status flags are packed {gnt0,gnt1,accept0,accept1,rvalid0,rvalid1,mem_rd,mem_wr,busy}.
module tb_mem_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] RD   = 4'b1100;
    localparam logic [3:0] RDL  = 4'b1101;
    localparam logic [3:0] WR   = 4'b1010;
    localparam logic [3:0] BOTH = 4'b1110;

    localparam logic [31:0] F_IDLE    = 32'b000000000;
    localparam logic [31:0] G0RD      = 32'b101000101;
    localparam logic [31:0] G0RDV0    = 32'b101010101;
    localparam logic [31:0] G1RD      = 32'b010100101;
    localparam logic [31:0] G1RDV1    = 32'b010101101;
    localparam logic [31:0] G1RDV0    = 32'b010110101;
    localparam logic [31:0] G0WR      = 32'b101000011;
    localparam logic [31:0] G0WRSTALL = 32'b100000011;
    localparam logic [31:0] G0ONLY    = 32'b100000001;
    localparam logic [31:0] V0        = 32'b000010000;
    localparam logic [31:0] V1        = 32'b000001000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] memAddr0, memAddr1;
    int                assertCount = 0;
    int                failCount   = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(4), .RD_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
        return a ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        memAddr0 <= bus.mem_addr;
        memAddr1 <= memAddr0;
    end
    assign bus.mem_data_out = memWord(memAddr1);

    function automatic logic [31:0] obsFlags();
        return {23'b0, bus.gnt0, bus.gnt1, bus.accept0, bus.accept1,
                bus.rvalid0, bus.rvalid1, bus.mem_rd, bus.mem_wr, bus.busy};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, then settle before checks.
    task automatic applyStimulus(input logic [3:0] p0, input logic [15:0] a0,
                                 input logic [3:0] p1, input logic [15:0] a1, input logic stall);
        @(negedge clk);
        {bus.req0, bus.rd0, bus.wr0, bus.last0} = p0;
        bus.addr0  = a0;
        bus.wdata0 = a0 ^ 16'hFFFF;
        {bus.req1, bus.rd1, bus.wr1, bus.last1} = p1;
        bus.addr1  = a1;
        bus.wdata1 = a1 ^ 16'hFFFF;
        bus.mem_stall = stall;
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        {bus.req0, bus.rd0, bus.wr0, bus.last0, bus.req1, bus.rd1, bus.wr1, bus.last1} = 8'h00;
        bus.addr0 = '0; bus.wdata0 = '0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.mem_stall = 1'b0;
        repeat (2) @(negedge clk);
        #1 checkOutput("reset", obsFlags(), F_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        $display("[TB] mem_arbiter directed test");
        applyReset();

        // Four-beat read burst on port 0 ending on last.
        applyStimulus(RD,  16'h0100, NONE, 16'h0, 1'b0); checkOutput("b4.req", obsFlags(), F_IDLE);
        applyStimulus(RD,  16'h0100, NONE, 16'h0, 1'b0); checkOutput("b4.beat1", obsFlags(), G0RD);
        checkOutput("b4.addr1", 32'(bus.mem_addr), 32'h0100);
        applyStimulus(RD,  16'h0102, NONE, 16'h0, 1'b0); checkOutput("b4.beat2", obsFlags(), G0RD);
        applyStimulus(RD,  16'h0104, NONE, 16'h0, 1'b0); checkOutput("b4.beat3", obsFlags(), G0RDV0);
        checkOutput("b4.rdata0", 32'(bus.rdata), 32'(memWord(16'h0100)));
        applyStimulus(RDL, 16'h0106, NONE, 16'h0, 1'b0); checkOutput("b4.beat4", obsFlags(), G0RDV0);
        checkOutput("b4.rdata1", 32'(bus.rdata), 32'(memWord(16'h0102)));
        applyStimulus(NONE, 16'h0, NONE, 16'h0, 1'b0);   checkOutput("b4.ret2", obsFlags(), V0);
        checkOutput("b4.rdata2", 32'(bus.rdata), 32'(memWord(16'h0104)));
        applyStimulus(NONE, 16'h0, NONE, 16'h0, 1'b0);   checkOutput("b4.ret3", obsFlags(), V0);
        checkOutput("b4.rdata3", 32'(bus.rdata), 32'(memWord(16'h0106)));
        applyStimulus(NONE, 16'h0, NONE, 16'h0, 1'b0);   checkOutput("b4.done", obsFlags(), F_IDLE);

        // Write burst, last never set, stall on beat 2 for three cycles.
        applyStimulus(WR, 16'h0200, NONE, 16'h0, 1'b0); checkOutput("st.req", obsFlags(), F_IDLE);
        applyStimulus(WR, 16'h0200, NONE, 16'h0, 1'b0); checkOutput("st.beat1", obsFlags(), G0WR);
        checkOutput("st.wdata", 32'(bus.mem_data_in), 32'hFDFF);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(WR, 16'h0202, NONE, 16'h0, 1'b1); checkOutput("st.stall", obsFlags(), G0WRSTALL);
        end
        applyStimulus(WR, 16'h0202, NONE, 16'h0, 1'b0); checkOutput("st.beat2", obsFlags(), G0WR);
        applyStimulus(WR, 16'h0204, NONE, 16'h0, 1'b0); checkOutput("st.beat3", obsFlags(), G0WR);
        applyStimulus(WR, 16'h0206, NONE, 16'h0, 1'b0); checkOutput("st.beat4", obsFlags(), G0WR);
        applyStimulus(NONE, 16'h0, NONE, 16'h0, 1'b0);  checkOutput("st.release", obsFlags(), F_IDLE);

        // Six-beat read with no last: release after four, regrant for the rest.
        applyStimulus(RD,  16'h0300, NONE, 16'h0, 1'b0); checkOutput("b6.req", obsFlags(), F_IDLE);
        applyStimulus(RD,  16'h0300, NONE, 16'h0, 1'b0); checkOutput("b6.beat1", obsFlags(), G0RD);
        applyStimulus(RD,  16'h0302, NONE, 16'h0, 1'b0); checkOutput("b6.beat2", obsFlags(), G0RD);
        applyStimulus(RD,  16'h0304, NONE, 16'h0, 1'b0); checkOutput("b6.beat3", obsFlags(), G0RDV0);
        applyStimulus(RD,  16'h0306, NONE, 16'h0, 1'b0); checkOutput("b6.beat4", obsFlags(), G0RDV0);
        applyStimulus(RD,  16'h0308, NONE, 16'h0, 1'b0); checkOutput("b6.gap", obsFlags(), V0);
        checkOutput("b6.rdata2", 32'(bus.rdata), 32'(memWord(16'h0304)));
        applyStimulus(RD,  16'h0308, NONE, 16'h0, 1'b0); checkOutput("b6.beat5", obsFlags(), G0RDV0);
        checkOutput("b6.addr5", 32'(bus.mem_addr), 32'h0308);
        applyStimulus(RDL, 16'h030A, NONE, 16'h0, 1'b0); checkOutput("b6.beat6", obsFlags(), G0RD);
        applyStimulus(NONE, 16'h0, NONE, 16'h0, 1'b0);   checkOutput("b6.ret5", obsFlags(), V0);
        checkOutput("b6.rdata5", 32'(bus.rdata), 32'(memWord(16'h0308)));
        applyStimulus(NONE, 16'h0, NONE, 16'h0, 1'b0);   checkOutput("b6.ret6", obsFlags(), V0);
        applyStimulus(NONE, 16'h0, NONE, 16'h0, 1'b0);   checkOutput("b6.done", obsFlags(), F_IDLE);

        // Port 0 final read followed by a port 1 grant; the return must be tagged for port 0.
        applyStimulus(RDL,  16'h0400, NONE, 16'h0,    1'b0); checkOutput("hx.req", obsFlags(), F_IDLE);
        applyStimulus(RDL,  16'h0400, RD,   16'h0500, 1'b0); checkOutput("hx.own0", obsFlags(), G0RD);
        applyStimulus(NONE, 16'h0,    RD,   16'h0500, 1'b0); checkOutput("hx.gap", obsFlags(), F_IDLE);
        applyStimulus(NONE, 16'h0,    RDL,  16'h0500, 1'b0); checkOutput("hx.own1", obsFlags(), G1RDV0);
        checkOutput("hx.rdata0", 32'(bus.rdata), 32'(memWord(16'h0400)));
        applyStimulus(NONE, 16'h0, NONE, 16'h0, 1'b0); checkOutput("hx.idle", obsFlags(), F_IDLE);
        applyStimulus(NONE, 16'h0, NONE, 16'h0, 1'b0); checkOutput("hx.ret1", obsFlags(), V1);
        checkOutput("hx.rdata1", 32'(bus.rdata), 32'(memWord(16'h0500)));

        // Both ports request together from reset.
        applyReset();
        applyStimulus(RD, 16'h0600, RD, 16'h0700, 1'b0); checkOutput("pr.req", obsFlags(), F_IDLE);
        applyStimulus(RD, 16'h0600, RD, 16'h0700, 1'b0); checkOutput("pr.beat1", obsFlags(), G1RD);
        checkOutput("pr.addr1", 32'(bus.mem_addr), 32'h0700);
        applyStimulus(RD, 16'h0600, RD,  16'h0702, 1'b0); checkOutput("pr.beat2", obsFlags(), G1RD);
        applyStimulus(RD, 16'h0600, RD,  16'h0704, 1'b0); checkOutput("pr.beat3", obsFlags(), G1RDV1);
        applyStimulus(RD, 16'h0600, RDL, 16'h0706, 1'b0); checkOutput("pr.beat4", obsFlags(), G1RDV1);
        applyStimulus(RD, 16'h0600, RD,  16'h0780, 1'b0); checkOutput("pr.gap", obsFlags(), V1);
        applyStimulus(RDL, 16'h0600, RDL, 16'h0780, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
        checkOutput("pr.second", obsFlags(), 32'b101001101);
        checkOutput("pr.addr2", 32'(bus.mem_addr), 32'h0600);
`else
        checkOutput("pr.second", obsFlags(), G1RDV1);
        checkOutput("pr.addr2", 32'(bus.mem_addr), 32'h0780);
`endif
        applyStimulus(NONE, 16'h0, NONE, 16'h0, 1'b0); checkOutput("pr.idle", obsFlags(), F_IDLE);
        applyStimulus(NONE, 16'h0, NONE, 16'h0, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
        checkOutput("pr.ret", obsFlags(), V0);
        checkOutput("pr.rdata", 32'(bus.rdata), 32'(memWord(16'h0600)));
`else
        checkOutput("pr.ret", obsFlags(), V1);
        checkOutput("pr.rdata", 32'(bus.rdata), 32'(memWord(16'h0780)));
`endif

        // Reset asserted asynchronously during beat 2 of a read burst.
        applyStimulus(RD, 16'h0800, NONE, 16'h0, 1'b0); checkOutput("rs.req", obsFlags(), F_IDLE);
        applyStimulus(RD, 16'h0800, NONE, 16'h0, 1'b0); checkOutput("rs.beat1", obsFlags(), G0RD);
        applyStimulus(RD, 16'h0802, NONE, 16'h0, 1'b0); checkOutput("rs.beat2", obsFlags(), G0RD);
        #2 rst_n = 1'b0;
        #1 checkOutput("rs.async", obsFlags(), F_IDLE);
        @(negedge clk);
        {bus.req0, bus.rd0, bus.wr0, bus.last0} = NONE;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(NONE, 16'h0, NONE, 16'h0, 1'b0); checkOutput("rs.noret", obsFlags(), F_IDLE);
        end

        // rd and wr together: grant held but nothing issued; dropping req releases.
        applyStimulus(BOTH, 16'h0900, NONE, 16'h0, 1'b0); checkOutput("pe.req", obsFlags(), F_IDLE);
        applyStimulus(BOTH, 16'h0900, NONE, 16'h0, 1'b0); checkOutput("pe.own1", obsFlags(), G0ONLY);
        applyStimulus(BOTH, 16'h0900, NONE, 16'h0, 1'b0); checkOutput("pe.own2", obsFlags(), G0ONLY);
        applyStimulus(NONE, 16'h0,    NONE, 16'h0, 1'b0); checkOutput("pe.drop", obsFlags(), G0ONLY);
        applyStimulus(NONE, 16'h0,    NONE, 16'h0, 1'b0); checkOutput("pe.release", obsFlags(), F_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
